// File: rtl/seg7_mux_driver.sv
// Time-multiplexed hex 7-segment driver with frame-synchronous double buffering.
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit0 always shown).
module seg7_mux_driver #(
  parameter int DIGITS      = 2,
  parameter int REFRESH_DIV = 50000,
  parameter bit SEG_ACT_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  value_vld,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pval_q, pval_d, sval_q, sval_d;
  logic [DIGITS-1:0]   pdp_q, pdp_d, sdp_q, sdp_d;
  logic                pend_q, pend_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_done_q;

  logic                tick, last_digit, wrap;
  logic [DIGITS-1:0]   blank;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;

  function automatic logic [6:0] hexmap(input logic [3:0] n);
    case (n)
      4'h0: hexmap = 7'h3F;
      4'h1: hexmap = 7'h06;
      4'h2: hexmap = 7'h5B;
      4'h3: hexmap = 7'h4F;
      4'h4: hexmap = 7'h66;
      4'h5: hexmap = 7'h6D;
      4'h6: hexmap = 7'h7D;
      4'h7: hexmap = 7'h07;
      4'h8: hexmap = 7'h7F;
      4'h9: hexmap = 7'h6F;
      4'hA: hexmap = 7'h77;
      4'hB: hexmap = 7'h7C;
      4'hC: hexmap = 7'h39;
      4'hD: hexmap = 7'h5E;
      4'hE: hexmap = 7'h79;
      default: hexmap = 7'h71;
    endcase
  endfunction

  assign tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
  assign wrap       = tick && last_digit;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit blanks only if it and every digit above it is zero.
  always_comb begin
    logic above_zero;
    blank      = '0;
    above_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      above_zero = above_zero && (sval_q[4*i +: 4] == 4'h0);
      blank[i]   = above_zero;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_d      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = sval_q[4*i +: 4];
        cur_dp    = sdp_q[i];
        cur_blank = blank[i];
        an_d[i]   = 1'b1;
      end
    end
    an_d  = an_d ^ {DIGITS{SEG_ACT_LOW}};
    seg_d = (cur_blank ? 7'h00 : hexmap(cur_nib)) ^ {7{SEG_ACT_LOW}};
    dp_d  = cur_dp ^ SEG_ACT_LOW;
  end

  // Shadow only changes on the frame wrap, so a scan never mixes two values.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    pval_d = pval_q;
    pdp_d  = pdp_q;
    pend_d = pend_q;
    sval_d = sval_q;
    sdp_d  = sdp_q;
    if (tick) begin
      idx_d = last_digit ? '0 : idx_q + IDX_W'(1);
    end
    if (wrap) begin
      if (value_vld) begin
        sval_d = value;
        sdp_d  = dp_in;
      end else if (pend_q) begin
        sval_d = pval_q;
        sdp_d  = pdp_q;
      end
      pend_d = 1'b0;
    end else if (value_vld) begin
      pval_d = value;
      pdp_d  = dp_in;
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pval_q       <= '0;
      pdp_q        <= '0;
      pend_q       <= 1'b0;
      sval_q       <= '0;
      sdp_q        <= '0;
      seg_q        <= {7{SEG_ACT_LOW}};
      dp_q         <= SEG_ACT_LOW;
      an_q         <= {DIGITS{SEG_ACT_LOW}};
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pval_q       <= pval_d;
      pdp_q        <= pdp_d;
      pend_q       <= pend_d;
      sval_q       <= sval_d;
      sdp_q        <= sdp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= wrap;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule
